frequency_controller: RTL
=========================

FREQUENCY_CONTROLLER -- requirements
Module: frequency_controller

Interface
REQ-001 Parameter M, default 4: width of every frequency setting (divide ratio of clk_fast).
REQ-002 Parameter INIT, default 2: setting driven after reset.
REQ-003 Parameter MIN_SETTING, default 2: smallest setting ever issued.
REQ-004 clk_fast  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  datapath requests a new setting.
REQ-007 req_setting  input  M  requested divide ratio.
REQ-008 req_ready  output  1  controller accepts a request this cycle.
REQ-009 done  output  1  one-cycle pulse: last accepted request is in effect.
REQ-010 current_setting  output  M  setting known to be in effect.
REQ-011 valid  output  1  load strobe to the divided-clock generator.
REQ-012 frequency_setting_request  output  M  setting presented to the divided-clock generator.

Function
REQ-013 States SHALL be SYNC, IDLE, ISSUE, SETTLE; req_ready SHALL be 1 only in IDLE and reset_n high.
REQ-014 Accept SHALL occur on an edge where state is IDLE and req_valid is 1; requests at other times are ignored, and the source holds req_valid until accepted.
REQ-015 On accept, pend SHALL capture max(req_setting, MIN_SETTING); odd values are legal.
REQ-016 If pend equals current_setting: state stays IDLE, valid stays 0, done is 1 the next cycle.
REQ-017 Otherwise the next state SHALL be ISSUE.
REQ-018 ISSUE lasts exactly 1 cycle: valid=1, frequency_setting_request=pend; settle counter loads current_setting+pend.
REQ-019 SETTLE lasts exactly (loaded count) cycles, counter decrementing each cycle; it exits when counter is 1.
REQ-020 On exit from SETTLE after an ISSUE: current_setting<=pend and done=1 in the first IDLE cycle.
REQ-021 The settle counter SHALL be M+1 bits; sums SHALL not truncate.
REQ-022 All outputs except req_ready SHALL be registered; frequency_setting_request SHALL hold its last issued value while valid is 0.
REQ-023 valid SHALL never be high for two consecutive cycles.
REQ-024 done and valid SHALL never be high in the same cycle.

Reset
REQ-025 While reset_n is 0: state=SYNC, valid=0, done=0, req_ready=0, frequency_setting_request=INIT, current_setting=INIT, counter cleared.
REQ-026 The first cycle after reset release SHALL be SYNC: valid=1, frequency_setting_request=INIT; counter loads (2^M-1)+INIT; next state SETTLE.
REQ-027 The SETTLE that follows SYNC SHALL end in IDLE with done kept at 0.
REQ-028 Reset asserted in any state, including mid-SETTLE, SHALL discard pend and the counter immediately; no done pulse is produced for the abandoned request.

Verification (M=4, INIT=2, MIN_SETTING=2)
REQ-029 Release reset -> cycle 1: valid=1, fsr=2; SETTLE 17 cycles; req_ready=1 on cycle 19; done stays 0 throughout.
REQ-030 From IDLE with current 2, accept 6 at edge T -> valid=1 with fsr=6 in cycle T+1 only; req_ready=0 in T+1..T+9; cycle T+10: done=1, current_setting=6, req_ready=1.
REQ-031 With current 6, request 6 -> valid stays 0; done=1 the next cycle; req_ready stays 1.
REQ-032 Request 0 and request 1 from current 4 -> each issues fsr=2; settle time 6 cycles.
REQ-033 Assert req_valid=1 with 9 during SETTLE -> request is ignored until IDLE, then accepted; exactly one valid pulse with fsr=9.
REQ-034 Pulse reset_n low mid-SETTLE of 2->15 -> outputs return to reset values immediately; no done pulse; SYNC re-issues fsr=2; current_setting=2.

Source files
------------

// File: rtl/frequency_controller.sv
// Frequency-setting handshake controller: issues a new divide ratio to the
// divided-clock generator, then waits out a settle interval before acknowledging.
module frequency_controller #(
  parameter int unsigned M           = 4,
  parameter int unsigned INIT        = 2,
  parameter int unsigned MIN_SETTING = 2
) (
  input  logic         clk_fast,
  input  logic         reset_n,
  input  logic         req_valid,
  input  logic [M-1:0] req_setting,
  output logic         req_ready,
  output logic         done,
  output logic [M-1:0] current_setting,
  output logic         valid,
  output logic [M-1:0] frequency_setting_request
);

  typedef enum logic [1:0] {SYNC, IDLE, ISSUE, SETTLE} state_t;

  localparam logic [M-1:0] INIT_S   = M'(INIT);
  localparam logic [M-1:0] MIN_S    = M'(MIN_SETTING);
  localparam logic [M:0]   CNT_ONE  = (M+1)'(1);
  localparam logic [M:0]   CNT_SYNC = (M+1)'((2**M) - 1 + INIT);

  state_t       state_q, state_d;
  logic [M:0]   cnt_q, cnt_d;
  logic [M-1:0] pend_q, pend_d;
  logic [M-1:0] cur_d, fsr_d, req_clamped;
  logic         valid_d, done_d;
  logic         sync_armed_q, sync_armed_d;
  logic         boot_q, boot_d;

  assign req_clamped = (req_setting < MIN_S) ? MIN_S : req_setting;
  assign req_ready   = (state_q == IDLE) && reset_n;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    cur_d        = current_setting;
    fsr_d        = frequency_setting_request;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    sync_armed_d = sync_armed_q;
    boot_d       = boot_q;
    case (state_q)
      // SYNC spans two edges: the first raises the strobe while still in SYNC,
      // the second loads the boot settle count.
      SYNC: begin
        if (!sync_armed_q) begin
          sync_armed_d = 1'b1;
          valid_d      = 1'b1;
          fsr_d        = INIT_S;
        end else begin
          cnt_d   = CNT_SYNC;
          state_d = SETTLE;
        end
      end
      IDLE: begin
        if (req_valid) begin
          pend_d = req_clamped;
          if (req_clamped == current_setting) begin
            done_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            fsr_d   = req_clamped;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = {1'b0, current_setting} + {1'b0, pend_q};
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (boot_q) begin
            boot_d = 1'b0;
          end else begin
            cur_d  = pend_q;
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk_fast or negedge reset_n) begin
    if (!reset_n) begin
      state_q                   <= SYNC;
      cnt_q                     <= '0;
      pend_q                    <= '0;
      sync_armed_q              <= 1'b0;
      boot_q                    <= 1'b1;
      valid                     <= 1'b0;
      done                      <= 1'b0;
      current_setting           <= INIT_S;
      frequency_setting_request <= INIT_S;
    end else begin
      state_q                   <= state_d;
      cnt_q                     <= cnt_d;
      pend_q                    <= pend_d;
      sync_armed_q              <= sync_armed_d;
      boot_q                    <= boot_d;
      valid                     <= valid_d;
      done                      <= done_d;
      current_setting           <= cur_d;
      frequency_setting_request <= fsr_d;
    end
  end

endmodule
